// File: rtl/axi4s_lfsr_pkg.sv
// ---------------------------------------------------------------------------
// axi4s_lfsr_pkg
//   Shared definitions for the multi-channel AXI4-Stream LFSR scrambler:
//   default feedback polynomial and seed, the stream-ID width rule, and the
//   zero-seed substitution used when software writes an all-zero seed.
//   No ports (package).
// ---------------------------------------------------------------------------
package axi4s_lfsr_pkg;

    // Widest LFSR the seed helper handles; callers cast to their own width.
    localparam int MAX_DEGREE = 64;

    localparam logic [15:0] DEFAULT_POLYNOMIAL = 16'b0110_1000_0000_0001;
    localparam logic [15:0] DEFAULT_SEED       = 16'h0001;

    // One channel still needs a one-bit tid on the bus.
    function automatic int tid_width(input int n_channels);
        return (n_channels > 1) ? $clog2(n_channels) : 1;
    endfunction

    // An all-zero LFSR state never leaves zero, so it is swapped for the
    // fallback seed.
    function automatic logic [MAX_DEGREE-1:0] nonzero_seed(
        input logic [MAX_DEGREE-1:0] value,
        input logic [MAX_DEGREE-1:0] fallback
    );
        return (value == '0) ? fallback : value;
    endfunction

endpackage

// File: rtl/axi4s_lfsr_mc_lfsr_core.sv
// ---------------------------------------------------------------------------
// lfsr_core
//   Combinational Fibonacci LFSR stepper. Advances the state OUTPUT_WIDTH
//   times per call; each step emits state[0] as the next keystream bit and
//   shifts in the parity of the tapped bits at the MSB.
//   Ports:
//     state_i  in  WIDTH         current LFSR state
//     ks_o     out OUTPUT_WIDTH  keystream word, bit 0 produced first
//     next_o   out WIDTH         state after OUTPUT_WIDTH steps
// ---------------------------------------------------------------------------
module lfsr_core
    import axi4s_lfsr_pkg::*;
#(
    parameter int                WIDTH        = 16,
    parameter logic [WIDTH-1:0]  POLYNOMIAL   = WIDTH'(DEFAULT_POLYNOMIAL),
    parameter int                OUTPUT_WIDTH = 8
) (
    input  logic [WIDTH-1:0]        state_i,
    output logic [OUTPUT_WIDTH-1:0] ks_o,
    output logic [WIDTH-1:0]        next_o
);

    logic [WIDTH-1:0] step_state;

    always_comb begin
        // NOTE: blocking assignments here are deliberate; each loop pass must
        // see the state produced by the previous pass within the same evaluation.
        step_state = state_i;
        ks_o       = '0;
        for (int i = 0; i < OUTPUT_WIDTH; i++) begin
            ks_o[i]    = step_state[0];
            step_state = {^(step_state & POLYNOMIAL), step_state[WIDTH-1:1]};
        end
        next_o = step_state;
    end

endmodule

// File: rtl/axi4s_lfsr_mc.sv
// ---------------------------------------------------------------------------
// axi4s_lfsr_mc
//   Multi-channel AXI4-Stream scrambler. Each tid owns a seed register and a
//   running LFSR state; a beat's tdata is XORed with the keystream word of
//   its channel and the channel state advances. One registered output stage
//   with full-throughput skid-free handshake.
//   Ports:
//     aclk, aresetn                        clock, async active-low reset
//     target_tvalid/tready/tdata/tlast/tid  input stream
//     initiator_tvalid/tready/tdata/tlast/tid  output stream
//     cfg_seed_valid/chan/value             seed register write strobe
//     cfg_bypass                            1 = pass data through, freeze state
// ---------------------------------------------------------------------------
module axi4s_lfsr_mc
    import axi4s_lfsr_pkg::*;
#(
    parameter int                     POLY_DEGREE    = 16,
    parameter logic [POLY_DEGREE-1:0] POLYNOMIAL     = POLY_DEGREE'(DEFAULT_POLYNOMIAL),
    parameter logic [POLY_DEGREE-1:0] SEED           = POLY_DEGREE'(DEFAULT_SEED),
    parameter int                     TDATA_WIDTH    = 8,
    parameter int                     N_CHANNELS     = 4,
    parameter bit                     RELOAD_ON_LAST = 1'b1,
    localparam int                    TID_WIDTH      = tid_width(N_CHANNELS)
) (
    input  logic                   aclk,
    input  logic                   aresetn,

    input  logic                   target_tvalid,
    output logic                   target_tready,
    input  logic [TDATA_WIDTH-1:0] target_tdata,
    input  logic                   target_tlast,
    input  logic [TID_WIDTH-1:0]   target_tid,

    output logic                   initiator_tvalid,
    input  logic                   initiator_tready,
    output logic [TDATA_WIDTH-1:0] initiator_tdata,
    output logic                   initiator_tlast,
    output logic [TID_WIDTH-1:0]   initiator_tid,

    input  logic                   cfg_seed_valid,
    input  logic [TID_WIDTH-1:0]   cfg_seed_chan,
    input  logic [POLY_DEGREE-1:0] cfg_seed_value,
    input  logic                   cfg_bypass
);

    // Per-channel context
    logic [POLY_DEGREE-1:0] seed_q  [N_CHANNELS];
    logic [POLY_DEGREE-1:0] seed_d  [N_CHANNELS];
    logic [POLY_DEGREE-1:0] state_q [N_CHANNELS];
    logic [POLY_DEGREE-1:0] state_d [N_CHANNELS];

    // Output register stage
    logic                   valid_q, valid_d;
    logic [TDATA_WIDTH-1:0] data_q,  data_d;
    logic                   last_q,  last_d;
    logic [TID_WIDTH-1:0]   tid_q,   tid_d;

    logic                   accept;
    logic                   chan_ok;
    logic                   scramble;
    logic [TID_WIDTH-1:0]   sel;
    logic [POLY_DEGREE-1:0] cur_state;
    logic [POLY_DEGREE-1:0] ks_next;
    logic [TDATA_WIDTH-1:0] ks;
    logic [POLY_DEGREE-1:0] seed_fixed;

    // Ready is forced low in reset so no handshake can complete while the
    // output register is being cleared.
    assign target_tready = aresetn && (!valid_q || initiator_tready);
    assign accept        = target_tvalid && target_tready;

    // Out-of-range tids are steered to channel 0 for the mux only; they never
    // scramble or update state.
    assign chan_ok   = (int'(target_tid) < N_CHANNELS);
    assign sel       = chan_ok ? target_tid : '0;
    assign cur_state = state_q[sel];
    assign scramble  = !cfg_bypass && chan_ok;

    assign seed_fixed = POLY_DEGREE'(nonzero_seed(MAX_DEGREE'(cfg_seed_value),
                                                  MAX_DEGREE'(SEED)));

    lfsr_core #(
        .WIDTH        (POLY_DEGREE),
        .POLYNOMIAL   (POLYNOMIAL),
        .OUTPUT_WIDTH (TDATA_WIDTH)
    ) u_lfsr_core (
        .state_i (cur_state),
        .ks_o    (ks),
        .next_o  (ks_next)
    );

    always_comb begin
        // NOTE: every variable gets a default before any condition so no path
        // leaves it unassigned (which would infer a latch).
        valid_d = accept || (valid_q && !initiator_tready);
        data_d  = data_q;
        last_d  = last_q;
        tid_d   = tid_q;
        if (accept) begin
            data_d = scramble ? (target_tdata ^ ks) : target_tdata;
            last_d = target_tlast;
            tid_d  = target_tid;
        end

        for (int c = 0; c < N_CHANNELS; c++) begin
            seed_d[c]  = seed_q[c];
            state_d[c] = state_q[c];
            if (accept && scramble && (sel == TID_WIDTH'(c))) begin
                state_d[c] = (RELOAD_ON_LAST && target_tlast) ? seed_q[c] : ks_next;
            end
            // A seed write wins over the beat's own state update; the beat
            // has already used the old state through the mux above.
            if (cfg_seed_valid && (cfg_seed_chan == TID_WIDTH'(c))) begin
                seed_d[c]  = seed_fixed;
                state_d[c] = seed_fixed;
            end
        end
    end

    // NOTE: non-blocking assignments for all registered state so every flop
    // samples its _d value from before this edge.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            tid_q   <= '0;
            // NOTE: the context arrays are reset too; a channel must restart
            // from SEED after reset, so these cannot be left as uninitialised RAM.
            for (int c = 0; c < N_CHANNELS; c++) begin
                seed_q[c]  <= SEED;
                state_q[c] <= SEED;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            tid_q   <= tid_d;
            for (int c = 0; c < N_CHANNELS; c++) begin
                seed_q[c]  <= seed_d[c];
                state_q[c] <= state_d[c];
            end
        end
    end

    assign initiator_tvalid = valid_q;
    assign initiator_tdata  = data_q;
    assign initiator_tlast  = last_q;
    assign initiator_tid    = tid_q;

endmodule

// File: tb/tb_axi4s_lfsr_mc.sv
// ---------------------------------------------------------------------------
// tb_axi4s_lfsr_mc
//   Scoreboard bench for axi4s_lfsr_mc. Keystream words from SEED=1 with the
//   default polynomial (bit 0 of each word produced first):
//     word0 = 8'h01, word1 = 8'h00, word2 = 8'hBD, word3 = 8'hD0
//   A loaded seed S gives word0 = S[7:0].
// ---------------------------------------------------------------------------
module tb_axi4s_lfsr_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Main DUT
    logic       t_valid, t_ready, t_last;
    logic [7:0] t_data;
    logic [1:0] t_tid;
    logic       o_valid, o_ready, o_last;
    logic [7:0] o_data;
    logic [1:0] o_tid;
    logic        cfg_v, bypass;
    logic [1:0]  cfg_chan;
    logic [15:0] cfg_val;

    // Two-instance chain
    logic       c_valid, c_ready, c_last;
    logic [7:0] c_data;
    logic [1:0] c_tid;
    logic       m_valid, m_ready, m_last;
    logic [7:0] m_data;
    logic [1:0] m_tid;
    logic       b_valid, b_last;
    logic [7:0] b_data;
    logic [1:0] b_tid;
    logic       c_rdy = 1'b1;
    logic       chain_on = 1'b0;

    axi4s_lfsr_mc dut (
        .aclk(clk), .aresetn(rst_n),
        .target_tvalid(t_valid), .target_tready(t_ready), .target_tdata(t_data),
        .target_tlast(t_last), .target_tid(t_tid),
        .initiator_tvalid(o_valid), .initiator_tready(o_ready), .initiator_tdata(o_data),
        .initiator_tlast(o_last), .initiator_tid(o_tid),
        .cfg_seed_valid(cfg_v), .cfg_seed_chan(cfg_chan), .cfg_seed_value(cfg_val),
        .cfg_bypass(bypass)
    );

    axi4s_lfsr_mc u_a (
        .aclk(clk), .aresetn(rst_n),
        .target_tvalid(c_valid), .target_tready(c_ready), .target_tdata(c_data),
        .target_tlast(c_last), .target_tid(c_tid),
        .initiator_tvalid(m_valid), .initiator_tready(m_ready), .initiator_tdata(m_data),
        .initiator_tlast(m_last), .initiator_tid(m_tid),
        .cfg_seed_valid(1'b0), .cfg_seed_chan(2'd0), .cfg_seed_value(16'h0000),
        .cfg_bypass(1'b0)
    );

    axi4s_lfsr_mc u_b (
        .aclk(clk), .aresetn(rst_n),
        .target_tvalid(m_valid), .target_tready(m_ready), .target_tdata(m_data),
        .target_tlast(m_last), .target_tid(m_tid),
        .initiator_tvalid(b_valid), .initiator_tready(c_rdy), .initiator_tdata(b_data),
        .initiator_tlast(b_last), .initiator_tid(b_tid),
        .cfg_seed_valid(1'b0), .cfg_seed_chan(2'd0), .cfg_seed_value(16'h0000),
        .cfg_bypass(1'b0)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [1:0] tid;
        int         acc;
    } exp_t;

    exp_t exp_q[$];
    exp_t chain_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int n_push  = 0;
    int n_pop   = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Random output ready for the chain, only while the chain test runs.
    always @(posedge clk) begin
        #1;
        c_rdy = chain_on ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- main monitor ----------------
    logic        pend = 1'b0;
    int          vis  = 0;
    logic [10:0] hold;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            pend = 1'b0;
        end else if (o_valid) begin
            if (!pend) begin
                pend = 1'b1;
                vis  = cyc;
                hold = {o_data, o_last, o_tid};
            end else begin
                check("payload_stable", 32'({o_data, o_last, o_tid}), 32'(hold));
            end
            if (o_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(1), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    n_pop++;
                    check("out_data", 32'(o_data), 32'(e.data));
                    check("out_last", 32'(o_last), 32'(e.last));
                    check("out_tid",  32'(o_tid),  32'(e.tid));
                    check("latency",  32'(vis),    32'(e.acc + 1));
                end
                pend = 1'b0;
            end
        end
    end

    // ---------------- chain monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && b_valid && c_rdy) begin
            if (chain_q.size() == 0) begin
                check("chain_unexpected", 32'(1), 32'(0));
            end else begin
                e = chain_q.pop_front();
                check("chain_data", 32'(b_data), 32'(e.data));
                check("chain_last", 32'(b_last), 32'(e.last));
                check("chain_tid",  32'(b_tid),  32'(e.tid));
            end
        end
    end

    // ---------------- stimulus tasks (entered at posedge+1) ----------------
    task automatic send(input logic [1:0] tid, input logic [7:0] data,
                        input logic last, input logic [7:0] exp_data);
        exp_t e;
        int   n = 0;
        t_valid = 1'b1;
        t_data  = data;
        t_last  = last;
        t_tid   = tid;
        @(negedge clk);
        while (!t_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (t_ready) begin
            e.data = exp_data;
            e.last = last;
            e.tid  = tid;
            e.acc  = cyc;
            exp_q.push_back(e);
            n_push++;
        end else begin
            check("send_timeout", 32'(0), 32'(1));
        end
        @(posedge clk);
        #1;
        t_valid = 1'b0;
    endtask

    task automatic send_chain(input logic [1:0] tid, input logic [7:0] data, input logic last);
        exp_t e;
        int   n = 0;
        c_valid = 1'b1;
        c_data  = data;
        c_last  = last;
        c_tid   = tid;
        @(negedge clk);
        while (!c_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (c_ready) begin
            e.data = data;
            e.last = last;
            e.tid  = tid;
            e.acc  = cyc;
            chain_q.push_back(e);
        end else begin
            check("chain_send_timeout", 32'(0), 32'(1));
        end
        @(posedge clk);
        #1;
        c_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || o_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size() == 0 && !o_valid), 32'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_load(input logic [1:0] chan, input logic [15:0] val);
        cfg_v    = 1'b1;
        cfg_chan = chan;
        cfg_val  = val;
        @(posedge clk);
        #1;
        cfg_v = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        rst_n   = 1'b0;
        t_valid = 1'b1;          // offered during reset; must not be taken
        t_data  = 8'hAA;
        t_last  = 1'b1;
        t_tid   = 2'd3;
        o_ready = 1'b1;
        cfg_v   = 1'b0;
        cfg_chan = 2'd0;
        cfg_val = 16'h0000;
        bypass  = 1'b0;
        c_valid = 1'b0;
        c_data  = 8'h00;
        c_last  = 1'b0;
        c_tid   = 2'd0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tready", 32'(t_ready), 32'(0));
        check("rst_tvalid", 32'(o_valid), 32'(0));
        check("rst_tdata",  32'(o_data),  32'(0));
        check("rst_tlast",  32'(o_last),  32'(0));
        check("rst_tid",    32'(o_tid),   32'(0));
        t_valid = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk);
        #1;

        // Keystream from SEED, back-to-back, one-cycle latency
        send(2'd0, 8'h00, 1'b0, 8'h01);
        send(2'd0, 8'h00, 1'b0, 8'h00);
        send(2'd0, 8'h00, 1'b0, 8'hBD);
        send(2'd0, 8'h00, 1'b0, 8'hD0);
        drain();

        // Interleaved channels are independent
        do_reset();
        send(2'd0, 8'h00, 1'b0, 8'h01);
        send(2'd1, 8'h00, 1'b0, 8'h01);
        send(2'd0, 8'h00, 1'b0, 8'h00);
        send(2'd1, 8'h00, 1'b0, 8'h00);
        drain();

        // Reload on tlast
        send(2'd2, 8'hFF, 1'b0, 8'hFE);
        send(2'd2, 8'h0F, 1'b0, 8'h0F);
        send(2'd2, 8'hA5, 1'b1, 8'h18);
        send(2'd2, 8'h3C, 1'b0, 8'h3D);
        drain();

        // Zero seed is replaced by SEED
        cfg_load(2'd2, 16'h0000);
        send(2'd2, 8'h00, 1'b0, 8'h01);
        // Load coincident with a beat on the same channel
        cfg_v = 1'b1; cfg_chan = 2'd2; cfg_val = 16'h1234;
        send(2'd2, 8'h00, 1'b0, 8'h00);
        cfg_v = 1'b0;
        send(2'd2, 8'h00, 1'b0, 8'h34);
        // Load coincident with a beat on a different channel
        cfg_v = 1'b1; cfg_chan = 2'd1; cfg_val = 16'h0077;
        send(2'd3, 8'h00, 1'b0, 8'h01);
        cfg_v = 1'b0;
        send(2'd1, 8'h00, 1'b0, 8'h77);

        // Bypass passes data and freezes state
        bypass = 1'b1;
        send(2'd3, 8'h5A, 1'b0, 8'h5A);
        bypass = 1'b0;
        send(2'd3, 8'h00, 1'b0, 8'h00);
        send(2'd3, 8'h00, 1'b0, 8'hBD);
        drain();

        // Backpressure: output held, second beat waits
        o_ready = 1'b0;
        send(2'd0, 8'h11, 1'b0, 8'hAC);
        fork
            send(2'd0, 8'h22, 1'b1, 8'hF2);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("stall_tready", 32'(t_ready), 32'(0));
                end
                @(posedge clk);
                #1;
                o_ready = 1'b1;
            end
        join
        drain();

        // Reset with a beat in flight discards it and all channel progress
        o_ready = 1'b0;
        send(2'd3, 8'h00, 1'b0, 8'hD0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_tvalid", 32'(o_valid), 32'(0));
        check("midrst_tdata",  32'(o_data),  32'(0));
        check("midrst_tid",    32'(o_tid),   32'(0));
        check("midrst_tready", 32'(t_ready), 32'(0));
        exp_q.delete();
        n_push--;                // the discarded beat is never popped
        o_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(2'd3, 8'h00, 1'b0, 8'h01);
        send(2'd1, 8'h00, 1'b0, 8'h01);
        send(2'd2, 8'h00, 1'b1, 8'h01);
        send(2'd2, 8'h00, 1'b0, 8'h01);
        drain();

        // Two instances in series restore the original stream
        chain_on = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send_chain(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                       1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        n = 0;
        while ((chain_q.size() != 0 || b_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chain_on = 1'b0;
        check("chain_drained", 32'(chain_q.size()), 32'(0));
        @(posedge clk);
        #1;

        check("main_queue_empty", 32'(exp_q.size()), 32'(0));
        check("beats_in_eq_out", 32'(n_pop), 32'(n_push));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
